// File: rtl/btn_arb_pkg.sv
// btn_arb_pkg: shared types, defaults and the round-robin pick helper for btn_event_arbiter.
package btn_arb_pkg;
  typedef enum logic {IDLE, OFFER} state_e;
  localparam int N_BTN_DEF = 4;
  localparam int ID_W_DEF = 2;
  localparam int MAX_BTN = 32;
  typedef struct packed {
    logic found;
    logic [4:0] idx;
  } pick_t;
  // Scan ptr+1, ptr+2, ... modulo n; the smallest offset wins, so iterate from the far end.
  function automatic pick_t rr_pick(input logic [MAX_BTN-1:0] pend, input logic [4:0] ptr, input int n);
    pick_t p;
    int j;
    p = '0;
    for (int k = MAX_BTN; k >= 1; k--) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && pend[5'(j)]) p = '{found: 1'b1, idx: 5'(j)};
    end
    return p;
  endfunction
endpackage

// File: rtl/btn_event_arbiter_if.sv
// btn_event_arbiter_if: valid/ready event channel from the arbiter to its consumer.
interface btn_event_arbiter_if #(parameter int ID_W = btn_arb_pkg::ID_W_DEF);
  logic evt_valid;
  logic evt_ready;
  logic evt_repeat;
  logic [ID_W-1:0] evt_id;
  modport master(output evt_valid, evt_id, evt_repeat, input evt_ready);
  modport slave(input evt_valid, evt_id, evt_repeat, output evt_ready);
endinterface

// File: rtl/btn_edge_rpt.sv
// btn_edge_rpt: per-button rising-edge detector; with AUTO_REPEAT_EN it also emits hold-to-repeat ticks.
module btn_edge_rpt
`ifdef AUTO_REPEAT_EN
#(
  parameter int HOLD_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W = 25
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic btn,
`ifdef AUTO_REPEAT_EN
  output logic tick,
`endif
  output logic rise
);
  logic prev_q, prev_d;
  always_comb prev_d = btn;
  // prev resets high so a button held through reset is not seen as a press.
  always_ff @(posedge clk) prev_q <= !rst ? 1'b1 : prev_d;
  assign rise = btn & ~prev_q;
`ifdef AUTO_REPEAT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic armed_q, armed_d, held;
  always_comb begin
    held = btn & prev_q;
    tick = held && cnt_q == CNT_W'(armed_q ? REPEAT_CYCLES - 1 : HOLD_CYCLES - 1);
    cnt_d = held && !tick ? cnt_q + 1'b1 : '0;
    armed_d = held & (armed_q | tick);
  end
  always_ff @(posedge clk) begin
    cnt_q <= !rst ? '0 : cnt_d;
    armed_q <= !rst ? 1'b0 : armed_d;
  end
`endif
endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: latches button presses and serialises them round-robin onto one valid/ready channel.
// Define AUTO_REPEAT_EN to add hold-to-repeat events flagged by evt_repeat.
module btn_event_arbiter
  import btn_arb_pkg::*;
#(
  parameter int N_BTN = N_BTN_DEF,
  parameter int ID_W = ID_W_DEF,
  parameter int HOLD_CYCLES = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_BTN-1:0] btn_in,
  btn_event_arbiter_if.master evt,
  output logic ovf
);
  logic [N_BTN-1:0] rise, tick, acc, pend_q, pend_d;
  logic [ID_W-1:0] id_q, id_d, ptr_q, ptr_d;
  logic ovf_q, ovf_d, grant, done;
  state_e state_q, state_d;
  pick_t pick;
  if ((1 << ID_W) < N_BTN || N_BTN > MAX_BTN || (64'd1 << CNT_W) < 64'(HOLD_CYCLES) ||
      (64'd1 << CNT_W) < 64'(REPEAT_CYCLES)) begin : g_bad_cfg
    $error("btn_event_arbiter: inconsistent parameters");
  end
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
`ifdef AUTO_REPEAT_EN
    btn_edge_rpt #(.HOLD_CYCLES(HOLD_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .CNT_W(CNT_W)) u_edge (
      .clk(clk), .rst(rst), .btn(btn_in[i]), .tick(tick[i]), .rise(rise[i]));
`else
    btn_edge_rpt u_edge (.clk(clk), .rst(rst), .btn(btn_in[i]), .rise(rise[i]));
    assign tick[i] = 1'b0;
`endif
  end
  always_comb begin
    pick = rr_pick(MAX_BTN'(pend_q), 5'(ptr_q), N_BTN);
    grant = state_q == IDLE && pick.found;
    done = state_q == OFFER && evt.evt_ready;
    acc = done ? N_BTN'(1) << id_q : '0;
    // A new request landing on the bit being accepted re-queues it instead of merging.
    pend_d = (pend_q & ~acc) | rise | tick;
    ovf_d = |((rise | tick) & pend_q & ~acc);
    state_d = grant ? OFFER : done ? IDLE : state_q;
    id_d = grant ? ID_W'(pick.idx) : id_q;
    ptr_d = done ? id_q : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      id_q <= '0;
      ptr_q <= ID_W'(N_BTN - 1);
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef AUTO_REPEAT_EN
  logic [N_BTN-1:0] rep_q, rep_d;
  logic erep_q, erep_d;
  always_comb begin
    rep_d = tick | (rep_q & ~acc & ~rise);
    erep_d = grant ? rep_q[ID_W'(pick.idx)] : erep_q;
  end
  always_ff @(posedge clk) begin
    rep_q <= !rst ? '0 : rep_d;
    erep_q <= !rst ? 1'b0 : erep_d;
  end
  assign evt.evt_repeat = erep_q;
`else
  assign evt.evt_repeat = 1'b0;
`endif
  assign evt.evt_valid = state_q == OFFER;
  assign evt.evt_id = id_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed and random stimulus against an event-level reference model.
module tb_btn_event_arbiter;
  localparam int N = 4, IW = 2, HOLD = 8, REP = 4;
  logic clk = 1'b0, rst = 1'b0, ovf;
  logic [N-1:0] btn = '0;
  int n_chk = 0, n_fail = 0, n_valid = 0, n_ovf = 0;
  int log_id[$];
  bit log_rep[$];
  btn_event_arbiter_if #(.ID_W(IW)) evt();
  btn_event_arbiter #(.N_BTN(N), .ID_W(IW), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .btn_in(btn), .evt(evt.master), .ovf(ovf));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference: pending requests per button, a single offered slot, and a rotating priority pointer.
  bit m_pend[N], m_rep[N], m_prev[N];
  int m_h[N];
  bit m_off, m_erep, m_ovf;
  int m_id, m_ptr;
  always @(posedge clk) begin : model
    int acc;
    bit nr, tk, rs;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_rep[i] = 0; m_prev[i] = 1; m_h[i] = 0;
      end
      m_off = 0; m_id = 0; m_erep = 0; m_ovf = 0; m_ptr = N - 1;
    end else begin
      acc = (m_off && evt.evt_ready) ? m_id : -1;
      if (m_off) begin
        if (evt.evt_ready) begin m_off = 0; m_ptr = m_id; end
      end else begin
        for (int k = N; k >= 1; k--)
          if (m_pend[(m_ptr + k) % N]) begin
            m_off = 1; m_id = (m_ptr + k) % N; m_erep = m_rep[m_id];
          end
      end
      m_ovf = 0;
      for (int i = 0; i < N; i++) begin
        rs = btn[i] && !m_prev[i];
        m_h[i] = (btn[i] && m_prev[i]) ? m_h[i] + 1 : 0;
        tk = 0;
`ifdef AUTO_REPEAT_EN
        tk = btn[i] && m_prev[i] && (m_h[i] == HOLD || (m_h[i] > HOLD && (m_h[i] - HOLD) % REP == 0));
`endif
        nr = rs || tk;
        if (nr && m_pend[i] && acc != i) m_ovf = 1;
        m_pend[i] = (m_pend[i] && acc != i) || nr;
        m_rep[i] = tk || (m_rep[i] && acc != i && !rs);
        m_prev[i] = btn[i];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("valid", evt.evt_valid, m_off);
    if (m_off) begin
      chk("id", evt.evt_id, m_id);
      chk("repeat", evt.evt_repeat, m_erep);
    end
    chk("ovf", ovf, m_ovf);
  end

  always @(negedge clk) if (rst) begin
    if (evt.evt_valid) n_valid++;
    if (ovf) n_ovf++;
    if (evt.evt_valid && evt.evt_ready) begin
      log_id.push_back(evt.evt_id);
      log_rep.push_back(evt.evt_repeat);
    end
  end

  initial begin
    evt.evt_ready = 1'b0;
    btn = 4'b0010;
    wait_cyc(3);
    rst = 1'b1;
    n_valid = 0;
    wait_cyc(5);
    chk("held_through_rst", n_valid, 0);
    btn = 4'b0000;
    wait_cyc(2);
    btn = 4'b0010;
    wait_cyc(1);
    chk("lat_e0", evt.evt_valid, 0);
    wait_cyc(1);
    chk("lat_e1_valid", evt.evt_valid, 1);
    chk("lat_e1_id", evt.evt_id, 1);
    evt.evt_ready = 1'b1;
    btn = 4'b0000;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    rst = 1'b1;
    wait_cyc(1);
    log_id.delete();
    btn = 4'b1111;
    wait_cyc(7);
    btn = 4'b0000;
    wait_cyc(3);
    chk("rr_count", log_id.size(), 4);
    for (int k = 0; k < 4 && k < log_id.size(); k++) chk("rr_order", log_id[k], k);
    evt.evt_ready = 1'b0;
    btn = 4'b0100;
    wait_cyc(2);
    n_ovf = 0;
    for (int c = 0; c < 20; c++) begin
      btn = (c < 5 || (c >= 8 && c < 11)) ? 4'b0100 : 4'b0000;
      wait_cyc(1);
      chk("stall_valid", evt.evt_valid, 1);
      chk("stall_id", evt.evt_id, 2);
    end
    chk("merge_ovf", n_ovf, 1);
    log_id.delete();
    evt.evt_ready = 1'b1;
    btn = 4'b0000;
    wait_cyc(7);
    chk("merge_single", log_id.size(), 1);
    evt.evt_ready = 1'b0;
    btn = 4'b1000;
    wait_cyc(2);
    btn = 4'b0000;
    wait_cyc(1);
    n_ovf = 0;
    btn = 4'b1000;
    evt.evt_ready = 1'b1;
    wait_cyc(1);
    evt.evt_ready = 1'b0;
    chk("requeue_gap", evt.evt_valid, 0);
    wait_cyc(1);
    chk("requeue_valid", evt.evt_valid, 1);
    chk("requeue_id", evt.evt_id, 3);
    chk("requeue_ovf", n_ovf, 0);
    evt.evt_ready = 1'b1;
    btn = 4'b0000;
    wait_cyc(1);
    evt.evt_ready = 1'b0;
    wait_cyc(2);
    btn = 4'b0101;
    wait_cyc(2);
    chk("pre_rst_valid", evt.evt_valid, 1);
    rst = 1'b0;
    wait_cyc(1);
    chk("mid_rst_valid", evt.evt_valid, 0);
    rst = 1'b1;
    n_valid = 0;
    evt.evt_ready = 1'b1;
    wait_cyc(6);
    chk("post_rst_quiet", n_valid, 0);
    btn = 4'b0000;
    wait_cyc(2);
`ifdef AUTO_REPEAT_EN
    log_id.delete();
    log_rep.delete();
    btn = 4'b0001;
    wait_cyc(14);
    btn = 4'b0000;
    wait_cyc(10);
    chk("rpt_count", log_id.size(), 3);
    for (int k = 0; k < 3 && k < log_rep.size(); k++) begin
      chk("rpt_id", log_id[k], 0);
      chk("rpt_flag", log_rep[k], k != 0);
    end
`endif
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
      evt.evt_ready = $urandom_range(0, 1) == 1;
      rst = $urandom_range(0, 99) != 0;
      wait_cyc(1);
    end
    rst = 1'b1;
    wait_cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
